dmem_arbiter: RTL and testbench

- Two-master arbiter and sequencer for the shared data memory (dmem) in the MA stage.
- Requesters: the CPU memory-access stage (port cpu_*) and the debug/program-loader port (port dbg_*).
- Latches one request at a time, drives dmem's read/write/address/writedata, waits out dmem busywait, returns readdata and per-port busywait.
- Fixed priority to CPU, with anti-starvation promotion of debug and a watchdog on stuck memory.

---
 rtl/dmem_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-master (CPU / debug) arbiter and sequencer for the shared data memory.
// Latches one request, drives dmem from holding registers until done, then releases the owner for one cycle.
module dmem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  cpu_read,
    input  logic [2:0]  cpu_write,
    input  logic [31:0] cpu_address,
    input  logic [31:0] cpu_writedata,
    output logic [31:0] cpu_readdata,
    output logic        cpu_busywait,
    input  logic [3:0]  dbg_read,
    input  logic [2:0]  dbg_write,
    input  logic [31:0] dbg_address,
    input  logic [31:0] dbg_writedata,
    output logic [31:0] dbg_readdata,
    output logic        dbg_busywait,
    output logic [3:0]  mem_read,
    output logic [2:0]  mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    input  logic        mem_busywait,
    output logic        grant_owner,
    output logic        timeout_err
);

    localparam logic [7:0]  STARVE_MAX   = 8'(STARVE_LIMIT);
    localparam logic [7:0]  WAIT_LAST    = 8'(TIMEOUT - 1);
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic [3:0]  mem_read_q, mem_read_d;
    logic [2:0]  mem_write_q, mem_write_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic [31:0] mem_writedata_q, mem_writedata_d;
    logic [31:0] cpu_readdata_q, cpu_readdata_d;
    logic [31:0] dbg_readdata_q, dbg_readdata_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [7:0]  starve_cnt_q, starve_cnt_d;
    logic        timeout_err_q, timeout_err_d;

    logic        cpu_req;
    logic        dbg_req;
    logic        pick_dbg;
    logic        grant_start;
    logic        sel_wen;
    logic [3:0]  sel_read;
    logic [2:0]  sel_write;
    logic [31:0] sel_address;
    logic [31:0] sel_writedata;
    logic        mem_done;
    logic        mem_stuck;

    // A write enable wins over a simultaneous read enable.
    assign cpu_req = cpu_read[3] | cpu_write[2];
    assign dbg_req = dbg_read[3] | dbg_write[2];

    assign pick_dbg    = dbg_req & (~cpu_req | (starve_cnt_q >= STARVE_MAX));
    assign grant_start = (state_q == IDLE) & (cpu_req | dbg_req);

    assign sel_read      = pick_dbg ? dbg_read      : cpu_read;
    assign sel_write     = pick_dbg ? dbg_write     : cpu_write;
    assign sel_address   = pick_dbg ? dbg_address   : cpu_address;
    assign sel_writedata = pick_dbg ? dbg_writedata : cpu_writedata;
    assign sel_wen       = sel_write[2];

    // The first GRANT cycle (wait_cnt == 0) gives dmem time to raise busywait.
    assign mem_done  = ~mem_busywait & (wait_cnt_q != 8'd0);
    assign mem_stuck = mem_busywait & (wait_cnt_q >= WAIT_LAST);

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        mem_read_d      = mem_read_q;
        mem_write_d     = mem_write_q;
        mem_address_d   = mem_address_q;
        mem_writedata_d = mem_writedata_q;
        cpu_readdata_d  = cpu_readdata_q;
        dbg_readdata_d  = dbg_readdata_q;
        wait_cnt_d      = wait_cnt_q;
        starve_cnt_d    = starve_cnt_q;
        timeout_err_d   = timeout_err_q;

        case (state_q)
            IDLE: begin
                wait_cnt_d = 8'd0;
                if (grant_start) begin
                    state_d         = GRANT;
                    owner_d         = pick_dbg;
                    mem_read_d      = sel_wen ? 4'b0000 : sel_read;
                    mem_write_d     = sel_wen ? sel_write : 3'b000;
                    mem_address_d   = sel_address;
                    mem_writedata_d = sel_writedata;
                end
            end
            GRANT: begin
                wait_cnt_d = wait_cnt_q + 8'd1;
                if (mem_done) begin
                    if (mem_read_q[3]) begin
                        if (owner_q) dbg_readdata_d = mem_readdata;
                        else         cpu_readdata_d = mem_readdata;
                    end
                    state_d     = RELEASE;
                    mem_read_d  = 4'b0000;
                    mem_write_d = 3'b000;
                end else if (mem_stuck) begin
                    if (owner_q) dbg_readdata_d = TIMEOUT_DATA;
                    else         cpu_readdata_d = TIMEOUT_DATA;
                    timeout_err_d = 1'b1;
                    state_d       = RELEASE;
                    mem_read_d    = 4'b0000;
                    mem_write_d   = 3'b000;
                end
            end
            RELEASE: begin
                state_d    = IDLE;
                wait_cnt_d = 8'd0;
            end
            default: begin
                state_d     = IDLE;
                mem_read_d  = 4'b0000;
                mem_write_d = 3'b000;
            end
        endcase

        // Counts CPU wins over a waiting debug port; cleared once debug wins or stops asking.
        if (!dbg_req) begin
            starve_cnt_d = 8'd0;
        end else if (grant_start) begin
            if (pick_dbg)
                starve_cnt_d = 8'd0;
            else if (starve_cnt_q < STARVE_MAX)
                starve_cnt_d = starve_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            owner_q         <= 1'b0;
            mem_read_q      <= 4'b0000;
            mem_write_q     <= 3'b000;
            mem_address_q   <= 32'd0;
            mem_writedata_q <= 32'd0;
            cpu_readdata_q  <= 32'd0;
            dbg_readdata_q  <= 32'd0;
            wait_cnt_q      <= 8'd0;
            starve_cnt_q    <= 8'd0;
            timeout_err_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            mem_read_q      <= mem_read_d;
            mem_write_q     <= mem_write_d;
            mem_address_q   <= mem_address_d;
            mem_writedata_q <= mem_writedata_d;
            cpu_readdata_q  <= cpu_readdata_d;
            dbg_readdata_q  <= dbg_readdata_d;
            wait_cnt_q      <= wait_cnt_d;
            starve_cnt_q    <= starve_cnt_d;
            timeout_err_q   <= timeout_err_d;
        end
    end

    // Only the owner is released, and only during its RELEASE cycle.
    assign cpu_busywait = cpu_req & ~((state_q == RELEASE) & ~owner_q);
    assign dbg_busywait = dbg_req & ~((state_q == RELEASE) &  owner_q);

    assign mem_read      = mem_read_q;
    assign mem_write     = mem_write_q;
    assign mem_address   = mem_address_q;
    assign mem_writedata = mem_writedata_q;
    assign cpu_readdata  = cpu_readdata_q;
    assign dbg_readdata  = dbg_readdata_q;
    assign grant_owner   = owner_q;
    assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic, checked every cycle
// against a transaction-level model of the arbiter and a small word-addressed dmem.
module tb_dmem_arbiter;

    localparam int STARVE_LIMIT = 4;
    localparam int TIMEOUT      = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  cpu_read = '0, dbg_read = '0;
    logic [2:0]  cpu_write = '0, dbg_write = '0;
    logic [31:0] cpu_address = '0, dbg_address = '0;
    logic [31:0] cpu_writedata = '0, dbg_writedata = '0;
    logic [31:0] cpu_readdata, dbg_readdata;
    logic        cpu_busywait, dbg_busywait;
    logic [3:0]  mem_read;
    logic [2:0]  mem_write;
    logic [31:0] mem_address, mem_writedata, mem_readdata;
    logic        mem_busywait = 1'b0;
    logic        grant_owner, timeout_err;

    logic [31:0] dmem [16];
    assign mem_readdata = dmem[mem_address[5:2]];

    dmem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_address(cpu_address),
        .cpu_writedata(cpu_writedata), .cpu_readdata(cpu_readdata), .cpu_busywait(cpu_busywait),
        .dbg_read(dbg_read), .dbg_write(dbg_write), .dbg_address(dbg_address),
        .dbg_writedata(dbg_writedata), .dbg_readdata(dbg_readdata), .dbg_busywait(dbg_busywait),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait),
        .grant_owner(grant_owner), .timeout_err(timeout_err)
    );

    initial forever #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name, input int cycles);
        n_chk++;
        n_fail++;
        $display("FAIL %s: no completion after %0d cycles (t=%0t)", name, cycles, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [3:0]  rd;
        logic [2:0]  wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic        owner;
    } txn_t;

    txn_t        m_t;
    bit          m_active;
    int          m_age;
    int          m_rel;
    logic        m_owner;
    int          m_starve;
    logic        m_terr;
    logic [31:0] m_rdata [2];

    task automatic model_step();
        logic rc, rdg, wen;
        bit   granted;
        logic gown;
        int   idx;
        rc  = cpu_read[3] | cpu_write[2];
        rdg = dbg_read[3] | dbg_write[2];
        granted = 0;
        gown = 1'b0;
        if (reset) begin
            m_active = 0; m_age = 0; m_rel = -1; m_owner = 1'b0;
            m_starve = 0; m_terr = 1'b0; m_rdata[0] = '0; m_rdata[1] = '0;
            m_t = '0;
            return;
        end
        if (m_rel >= 0) begin
            m_rel = -1;
        end else if (m_active) begin
            idx = int'(m_t.addr[5:2]);
            if (!mem_busywait && m_age >= 1) begin
                if (m_t.wr[2]) dmem[idx] = m_t.data;
                else           m_rdata[m_t.owner] = dmem[idx];
                m_active = 0;
                m_rel = int'(m_t.owner);
            end else if (mem_busywait && m_age + 1 >= TIMEOUT) begin
                m_terr = 1'b1;
                m_rdata[m_t.owner] = 32'hDEADBEEF;
                m_active = 0;
                m_rel = int'(m_t.owner);
            end else begin
                m_age++;
            end
        end else if (rc || rdg) begin
            gown = rdg && (!rc || m_starve >= STARVE_LIMIT);
            wen  = gown ? dbg_write[2] : cpu_write[2];
            m_t.owner = gown;
            m_t.addr  = gown ? dbg_address : cpu_address;
            m_t.data  = gown ? dbg_writedata : cpu_writedata;
            m_t.wr    = wen ? (gown ? dbg_write : cpu_write) : 3'b000;
            m_t.rd    = wen ? 4'b0000 : (gown ? dbg_read : cpu_read);
            m_active = 1; m_age = 0; m_owner = gown; granted = 1;
        end
        if (!rdg) m_starve = 0;
        else if (granted) m_starve = gown ? 0 : (m_starve < STARVE_LIMIT ? m_starve + 1 : m_starve);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) dmem[i] = 32'h01010101 * i;
        m_active = 0; m_age = 0; m_rel = -1; m_owner = 1'b0;
        m_starve = 0; m_terr = 1'b0; m_rdata[0] = '0; m_rdata[1] = '0; m_t = '0;
        forever begin
            @(posedge clock);
            model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        logic rc, rdg;
        @(posedge clock);
        #1;
        rc  = cpu_read[3] | cpu_write[2];
        rdg = dbg_read[3] | dbg_write[2];
        chk("grant_owner", 32'(grant_owner), 32'(m_owner));
        chk("timeout_err", 32'(timeout_err), 32'(m_terr));
        chk("cpu_readdata", cpu_readdata, m_rdata[0]);
        chk("dbg_readdata", dbg_readdata, m_rdata[1]);
        chk("cpu_busywait", 32'(cpu_busywait), 32'(rc && !(m_rel == 0)));
        chk("dbg_busywait", 32'(dbg_busywait), 32'(rdg && !(m_rel == 1)));
        chk("mem_read", 32'(mem_read), 32'(m_active ? m_t.rd : 4'b0000));
        chk("mem_write", 32'(mem_write), 32'(m_active ? m_t.wr : 3'b000));
        if (m_active) begin
            chk("mem_address", mem_address, m_t.addr);
            chk("mem_writedata", mem_writedata, m_t.data);
        end
    end

    // ---------------- dmem busywait driver ----------------
    int busy_mode = 1;   // 0 random, 1 busy for 'lat' grant cycles, 2 stuck high
    int lat = 2;
    initial begin
        int gcnt = 0;
        forever begin
            @(negedge clock);
            case (busy_mode)
                0: mem_busywait = ($urandom_range(0, 99) < 45);
                1: begin
                    if (mem_read[3] || mem_write[2]) begin
                        mem_busywait = (gcnt < lat);
                        gcnt++;
                    end else begin
                        gcnt = 0;
                        mem_busywait = 1'b0;
                    end
                end
                default: mem_busywait = 1'b1;
            endcase
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_port(input bit p, input logic [3:0] r, input logic [2:0] w,
                            input logic [31:0] a, input logic [31:0] d);
        if (p) begin dbg_read = r; dbg_write = w; dbg_address = a; dbg_writedata = d; end
        else   begin cpu_read = r; cpu_write = w; cpu_address = a; cpu_writedata = d; end
    endtask

    task automatic wait_release(input bit p, input int bound, output int hi);
        bit done;
        hi = 0;
        done = 0;
        while (!done) begin
            @(posedge clock);
            #1;
            if (!(p ? dbg_busywait : cpu_busywait)) done = 1;
            else begin
                hi++;
                if (hi >= bound) begin
                    bound_fail(p ? "dbg_release" : "cpu_release", hi);
                    done = 1;
                end
            end
        end
    endtask

    bit          pact [2];
    logic [31:0] waddr;

    task automatic rand_request(input bit p);
        int kind;
        logic [3:0] r;
        logic [2:0] w;
        kind = $urandom_range(0, 2);
        r = {kind != 1, 3'($urandom_range(0, 7))};
        w = {kind != 0, 2'($urandom_range(0, 3))};
        set_port(p, r, w, $urandom() & 32'hFFFF_FFFC, $urandom());
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int hi, cg;
        bit seen;
        repeat (2) @(negedge clock);
        chk("rst_grant_owner", 32'(grant_owner), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_cpu_readdata", cpu_readdata, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Write then read back with dmem busy for 2 cycles.
        busy_mode = 1; lat = 2;
        set_port(0, 4'b0000, 3'b100, 32'h04, 32'hAABBCCDD);
        wait_release(0, 30, hi);
        chk("t1_write_busy_cycles", 32'(hi), 32'd3);
        @(posedge clock); #1;
        chk("t1_busy_after_release", 32'(cpu_busywait), 32'd1);
        @(negedge clock);
        set_port(0, 4'b1000, 3'b000, 32'h04, 32'h0);
        wait_release(0, 30, hi);
        chk("t1_read_busy_cycles", 32'(hi), 32'd3);
        chk("t1_readdata", cpu_readdata, 32'hAABBCCDD);
        @(negedge clock);
        set_port(0, 4'b0000, 3'b000, 32'h0, 32'h0);
        @(negedge clock);

        // Simultaneous requests: CPU first, debug next.
        lat = 1;
        set_port(0, 4'b1000, 3'b000, 32'h10, 32'h0);
        set_port(1, 4'b0000, 3'b100, 32'h08, 32'h11223344);
        @(posedge clock); #1;
        chk("t2_owner_cpu", 32'(grant_owner), 32'd0);
        wait_release(0, 30, hi);
        chk("t2_dbg_still_waiting", 32'(dbg_busywait), 32'd1);
        @(negedge clock);
        set_port(0, 4'b0000, 3'b000, 32'h0, 32'h0);
        wait_release(1, 30, hi);
        chk("t2_owner_dbg", 32'(grant_owner), 32'd1);
        @(negedge clock);
        set_port(1, 4'b0000, 3'b000, 32'h0, 32'h0);
        set_port(0, 4'b1000, 3'b000, 32'h08, 32'h0);
        wait_release(0, 30, hi);
        chk("t2_readback", cpu_readdata, 32'h11223344);
        @(negedge clock);
        set_port(0, 4'b0000, 3'b000, 32'h0, 32'h0);
        @(negedge clock);

        // Continuous CPU traffic with debug pending: debug wins after STARVE_LIMIT CPU grants.
        set_port(0, 4'b1000, 3'b000, 32'h0C, 32'h0);
        set_port(1, 4'b1000, 3'b000, 32'h04, 32'h0);
        cg = 0; seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clock); #1;
            if (!cpu_busywait) cg++;
            if (!dbg_busywait) seen = 1;
        end
        if (!seen) bound_fail("t3_dbg_grant", 200);
        chk("t3_cpu_grants_before_dbg", 32'(cg), 32'd4);
        chk("t3_dbg_readdata", dbg_readdata, 32'hAABBCCDD);
        @(negedge clock);
        set_port(0, 4'b0000, 3'b000, 32'h0, 32'h0);
        set_port(1, 4'b0000, 3'b000, 32'h0, 32'h0);
        repeat (2) @(negedge clock);

        // Flush mid-GRANT: request drops and address changes, transaction still completes.
        lat = 3;
        set_port(0, 4'b1000, 3'b000, 32'h04, 32'h0);
        @(posedge clock); #1;
        chk("t6_granted_read", 32'(mem_read), 32'h8);
        @(negedge clock);
        cpu_read = 4'b0000; cpu_address = 32'h3C;
        @(posedge clock); #1;
        chk("t6_busy_dropped", 32'(cpu_busywait), 32'd0);
        chk("t6_latched_addr", mem_address, 32'h04);
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(posedge clock); #1;
            if (mem_read == 4'b0000) seen = 1;
        end
        if (!seen) bound_fail("t6_flush_complete", 30);
        chk("t6_captured", cpu_readdata, 32'hAABBCCDD);
        repeat (2) @(negedge clock);

        // Watchdog: dmem stuck busy.
        busy_mode = 2;
        set_port(0, 4'b1000, 3'b000, 32'h20, 32'h0);
        wait_release(0, 40, hi);
        chk("t4_grant_cycles", 32'(hi), 32'd8);
        chk("t4_readdata", cpu_readdata, 32'hDEADBEEF);
        chk("t4_timeout_err", 32'(timeout_err), 32'd1);
        @(negedge clock);
        set_port(0, 4'b0000, 3'b000, 32'h0, 32'h0);
        busy_mode = 1; lat = 1;
        @(negedge clock);
        set_port(1, 4'b0000, 3'b100, 32'h24, 32'h5555AAAA);
        wait_release(1, 30, hi);
        chk("t4_timeout_sticky", 32'(timeout_err), 32'd1);
        @(negedge clock);
        set_port(1, 4'b0000, 3'b000, 32'h0, 32'h0);
        @(negedge clock);

        // Asynchronous reset in the middle of a debug write.
        lat = 5;
        set_port(1, 4'b0000, 3'b100, 32'h30, 32'h77);
        @(posedge clock); #1;
        chk("t5_write_granted", 32'(mem_write), 32'h4);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_async_mem_write", 32'(mem_write), 32'd0);
        chk("t5_async_mem_read", 32'(mem_read), 32'd0);
        chk("t5_async_owner", 32'(grant_owner), 32'd0);
        chk("t5_async_terr", 32'(timeout_err), 32'd0);
        chk("t5_async_dbg_rdata", dbg_readdata, 32'd0);
        chk("t5_async_mem_addr", mem_address, 32'd0);
        @(negedge clock);
        set_port(1, 4'b0000, 3'b000, 32'h0, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        lat = 1;
        set_port(0, 4'b1000, 3'b000, 32'h08, 32'h0);
        wait_release(0, 30, hi);
        chk("t5_after_reset_read", cpu_readdata, 32'h11223344);
        @(negedge clock);
        set_port(0, 4'b0000, 3'b000, 32'h0, 32'h0);
        @(negedge clock);

        // Randomized traffic on both ports with random dmem latency.
        busy_mode = 0;
        pact[0] = 0; pact[1] = 0;
        for (int c = 0; c < 2500; c++) begin
            @(negedge clock);
            for (int p = 0; p < 2; p++) begin
                int r;
                r = $urandom_range(0, 99);
                if (pact[p] && !(p == 1 ? dbg_busywait : cpu_busywait)) begin
                    if (r < 70) begin
                        set_port(p[0], 4'b0000, 3'b000, 32'h0, 32'h0);
                        pact[p] = 0;
                    end
                end else if (pact[p] && r < 3) begin
                    set_port(p[0], 4'b0000, 3'b000, 32'h0, 32'h0);
                    pact[p] = 0;
                end else if (pact[p] && r < 7) begin
                    waddr = $urandom() & 32'hFFFF_FFFC;
                    if (p == 1) begin dbg_address = waddr; dbg_writedata = $urandom(); end
                    else        begin cpu_address = waddr; cpu_writedata = $urandom(); end
                end else if (!pact[p] && r < 40) begin
                    rand_request(p[0]);
                    pact[p] = 1;
                end
            end
        end
        @(negedge clock);
        set_port(0, 4'b0000, 3'b000, 32'h0, 32'h0);
        set_port(1, 4'b0000, 3'b000, 32'h0, 32'h0);
        repeat (20) @(negedge clock);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
